// File: rtl/led_anim_pkg.sv
// Shared types for the LED animation sequencer: FSM states, animation modes
// and the gap counter width.
package led_anim_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RAMP,
      ST_GAP,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      MODE_FWD_SINGLE = 2'b00,
      MODE_FWD_LOOP   = 2'b01,
      MODE_PINGPONG   = 2'b10,
      MODE_REV_SINGLE = 2'b11
   } mode_t;

   localparam int GAP_W = 6;

endpackage

// File: rtl/gap_counter.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module gap_counter
   import led_anim_pkg::*;
#(
   parameter int W = GAP_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/led_sequencer.sv
// Steps the breathing ramp across a bank of LEDs: pulses the ramp controller,
// routes its PWM onto the selected LED, then advances per the animation mode.
module led_sequencer
   import led_anim_pkg::*;
#(
   parameter int               N_LEDS = 8,
   parameter int               IDX_W  = 3,
   parameter logic [GAP_W-1:0] GAP    = 6'd10,
   parameter int               REP_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic [REP_W-1:0]  repeats,
   input  logic              pwm_in,
   input  logic              ramp_done,
   output logic              ramp_start,
   output logic [N_LEDS-1:0] led_out,
   output logic [IDX_W-1:0]  cur_idx,
   output logic              busy,
   output logic              seq_done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LEDS - 1);
   localparam logic [IDX_W-1:0] PEN_IDX  = IDX_W'(N_LEDS - 2);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
   localparam bit               HAS_GAP  = (GAP != '0);

   // Ramp handshake: ramp_start is a single-cycle request with no back-pressure;
   // ramp_done is a single-cycle completion pulse, honoured only in ST_RAMP.
   state_t             state;
   mode_t              mode_q;
   logic [REP_W-1:0]   reps_q;
   logic [REP_W-1:0]   rem_q;
   logic               dir_up;

   logic [GAP_W-1:0]   gap_count;
   logic               gap_zero;
   logic               gap_load;
   logic               gap_en;
   logic               do_adv;

   logic [IDX_W-1:0]   adv_idx;
   logic               adv_dir_up;
   logic               adv_finish;
   logic               pass_end;

   assign gap_load = (state == ST_RAMP) && ramp_done && !stop && HAS_GAP;
   assign gap_en   = (state == ST_GAP);
   assign do_adv   = ((state == ST_RAMP) && ramp_done && !HAS_GAP) ||
                     (gap_en && (gap_count == GAP_W'(1) || gap_zero));

   gap_counter #(.W(GAP_W)) u_gap (
      .clk   (clk),
      .rst   (rst),
      .load  (gap_load),
      .value (GAP),
      .en    (gap_en),
      .count (gap_count),
      .zero  (gap_zero)
   );

   always_comb begin
      adv_idx    = cur_idx;
      adv_dir_up = dir_up;
      adv_finish = 1'b0;
      pass_end   = 1'b0;
      case (mode_q)
         MODE_FWD_SINGLE: begin
            if (cur_idx == LAST_IDX) adv_finish = 1'b1;
            else                     adv_idx    = cur_idx + 1'b1;
         end
         MODE_REV_SINGLE: begin
            if (cur_idx == '0) adv_finish = 1'b1;
            else               adv_idx    = cur_idx - 1'b1;
         end
         MODE_FWD_LOOP: begin
            if (cur_idx == LAST_IDX) begin
               pass_end = 1'b1;
               adv_idx  = '0;
            end else begin
               adv_idx = cur_idx + 1'b1;
            end
         end
         MODE_PINGPONG: begin
            // Turn at the ends without relighting the endpoint LED.
            if (dir_up) begin
               if (cur_idx != LAST_IDX) begin
                  adv_idx = cur_idx + 1'b1;
               end else if (N_LEDS == 2) begin
                  pass_end = 1'b1;
                  adv_idx  = '0;
               end else begin
                  adv_dir_up = 1'b0;
                  adv_idx    = PEN_IDX;
               end
            end else if (cur_idx <= ONE_IDX) begin
               pass_end   = 1'b1;
               adv_idx    = '0;
               adv_dir_up = 1'b1;
            end else begin
               adv_idx = cur_idx - 1'b1;
            end
         end
         default: ;
      endcase
      if (pass_end && reps_q != '0 && rem_q == REP_W'(1)) adv_finish = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         mode_q     <= MODE_FWD_SINGLE;
         reps_q     <= '0;
         rem_q      <= '0;
         dir_up     <= 1'b1;
         cur_idx    <= '0;
         ramp_start <= 1'b0;
         busy       <= 1'b0;
         seq_done   <= 1'b0;
      end else if (state != ST_IDLE && stop) begin
         state      <= ST_IDLE;
         ramp_start <= 1'b0;
         busy       <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         ramp_start <= 1'b0;
         seq_done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (go && !stop) begin
                  mode_q     <= mode_t'(mode);
                  reps_q     <= repeats;
                  rem_q      <= repeats;
                  cur_idx    <= (mode == MODE_REV_SINGLE) ? LAST_IDX : '0;
                  dir_up     <= 1'b1;
                  state      <= ST_START;
                  ramp_start <= 1'b1;
                  busy       <= 1'b1;
               end
            end
            ST_START: state <= ST_RAMP;
            ST_RAMP, ST_GAP: begin
               if (do_adv) begin
                  if (adv_finish) begin
                     state    <= ST_DONE;
                     seq_done <= 1'b1;
                  end else begin
                     state      <= ST_START;
                     ramp_start <= 1'b1;
                     cur_idx    <= adv_idx;
                     dir_up     <= adv_dir_up;
                     if (pass_end && reps_q != '0) rem_q <= rem_q - 1'b1;
                  end
               end else if (state == ST_RAMP && ramp_done) begin
                  state <= ST_GAP;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      led_out = '0;
      if (state == ST_RAMP) led_out[cur_idx] = pwm_in;
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: two instances (GAP=2 and GAP=0) share stimulus, an
// auto-responder answers ramp_start with ramp_done, a monitor records starts.
module tb_led_sequencer;

   localparam int N        = 4;
   localparam int IW       = 2;
   localparam int RW       = 4;
   localparam int RD_DELAY = 20;

   // clock/reset
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          rst_a, rst_b, go, stop, sel;
   logic [1:0]    mode;
   logic [RW-1:0] repeats;
   logic          resp_done, spur_done, ramp_done;
   logic          pwm_level, pwm_tog_en, pwm_tog, pwm_in;
   logic          rs_a, rs_b, busy_a, busy_b, sd_a, sd_b;
   logic [N-1:0]  led_a, led_b;
   logic [IW-1:0] idx_a, idx_b;
   logic          rs_m, sd_m;
   logic [N-1:0]  led_m;
   logic [IW-1:0] idx_m;

   assign ramp_done = resp_done | spur_done;
   assign pwm_in    = pwm_tog_en ? pwm_tog : pwm_level;
   assign rs_m      = sel ? rs_b  : rs_a;
   assign sd_m      = sel ? sd_b  : sd_a;
   assign led_m     = sel ? led_b : led_a;
   assign idx_m     = sel ? idx_b : idx_a;

   led_sequencer #(.N_LEDS(N), .IDX_W(IW), .GAP(6'd2), .REP_W(RW)) dut_a (
      .clk(clk), .rst(rst_a), .go(go), .stop(stop), .mode(mode), .repeats(repeats),
      .pwm_in(pwm_in), .ramp_done(ramp_done), .ramp_start(rs_a), .led_out(led_a),
      .cur_idx(idx_a), .busy(busy_a), .seq_done(sd_a)
   );

   led_sequencer #(.N_LEDS(N), .IDX_W(IW), .GAP(6'd0), .REP_W(RW)) dut_b (
      .clk(clk), .rst(rst_b), .go(go), .stop(stop), .mode(mode), .repeats(repeats),
      .pwm_in(pwm_in), .ramp_done(ramp_done), .ramp_start(rs_b), .led_out(led_b),
      .cur_idx(idx_b), .busy(busy_b), .seq_done(sd_b)
   );

   // scoreboard state
   logic [IW-1:0] exp_q[$];
   logic [IW-1:0] got_q[$];
   int start_q[$];
   int total = 0, bad = 0;
   int done_cnt = 0, done_cyc = 0, lit_cnt = 0, stray_cnt = 0, last_rd_cyc = -10;

   // ramp controller model: ramp_done RD_DELAY cycles after each ramp_start
   initial begin
      int rd_cnt;
      rd_cnt = 0;
      resp_done = 1'b0;
      pwm_tog = 1'b0;
      forever begin
         @(negedge clk);
         resp_done = 1'b0;
         pwm_tog = ~pwm_tog;
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               resp_done = 1'b1;
               last_rd_cyc = cyc;
            end
         end
         if (rs_m) rd_cnt = RD_DELAY;
      end
   end

   // output monitor
   initial begin
      logic [N-1:0] mask;
      forever begin
         @(negedge clk);
         #1;
         if (rs_m === 1'b1) begin
            got_q.push_back(idx_m);
            start_q.push_back(cyc);
         end
         if (sd_m === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         mask = N'(1) << idx_m;
         if (led_m != '0) lit_cnt++;
         if ((led_m & ~mask) != '0) stray_cnt++;
      end
   end

   // driver tasks
   task automatic start_seq(input logic [1:0] m, input logic [RW-1:0] r, output int go_cyc);
      @(negedge clk);
      got_q.delete();
      start_q.delete();
      mode = m;
      repeats = r;
      go = 1'b1;
      go_cyc = cyc;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int d0, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #2;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      total++;
      if ({rs_a, led_a, idx_a, busy_a, sd_a} !== '0) begin
         bad++;
         $display("FAIL reset_a: got start=%b led=%b idx=%0d busy=%b done=%b want all 0",
                  rs_a, led_a, idx_a, busy_a, sd_a);
      end
      total++;
      if ({rs_b, led_b, idx_b, busy_b, sd_b} !== '0) begin
         bad++;
         $display("FAIL reset_b: got start=%b led=%b idx=%0d busy=%b done=%b want all 0",
                  rs_b, led_b, idx_b, busy_b, sd_b);
      end
      @(negedge clk);
      rst_a = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fwd_single;
      int gc, d0, n;
      bit ok;
      logic [IW-1:0] e, g;
      d0 = done_cnt;
      for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
      start_seq(2'b00, '0, gc);
      wait_done(400, d0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL fwd_timeout: got no seq_done want one"); end
      total++;
      if (start_q.size() == 0 || start_q[0] !== gc + 1) begin
         bad++;
         $display("FAIL fwd_latency: got first start cycle %0d want %0d",
                  (start_q.size() > 0) ? start_q[0] : -1, gc + 1);
      end
      for (int i = 1; i < start_q.size(); i++) begin
         total++;
         if (start_q[i] - start_q[i-1] !== 23) begin
            bad++;
            $display("FAIL fwd_spacing[%0d]: got %0d want 23", i, start_q[i] - start_q[i-1]);
         end
      end
      total++;
      if (done_cyc - last_rd_cyc !== 3) begin
         bad++;
         $display("FAIL fwd_done_lat: got %0d want 3", done_cyc - last_rd_cyc);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL fwd_idx[%0d]: got %0d want %0d", i, g, e); end
      end
      total++;
      if (got_q.size() != 0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL fwd_counts: got extra_starts=%0d dones=%0d want 0 and 1",
                  got_q.size(), done_cnt - d0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_pingpong;
      int gc, d0, n;
      int pp[12];
      bit ok;
      logic [IW-1:0] e, g;
      pp = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};
      d0 = done_cnt;
      for (int i = 0; i < 12; i++) exp_q.push_back(IW'(pp[i]));
      start_seq(2'b10, RW'(2), gc);
      wait_done(800, d0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL pp_timeout: got no seq_done want one"); end
      @(negedge clk);
      #2;
      total++;
      if (busy_a !== 1'b0 || idx_a !== IW'(1)) begin
         bad++;
         $display("FAIL pp_after_done: got busy=%b idx=%0d want busy=0 idx=1", busy_a, idx_a);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL pp_idx[%0d]: got %0d want %0d", i, g, e); end
      end
      total++;
      if (got_q.size() != 0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL pp_counts: got extra_starts=%0d dones=%0d want 0 and 1",
                  got_q.size(), done_cnt - d0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_loop_stop;
      int gc, d0, n, ns;
      logic [IW-1:0] e, g;
      pwm_level = 1'b1;
      d0 = done_cnt;
      for (int p = 0; p < 3; p++)
         for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
      exp_q.push_back('0);
      start_seq(2'b01, '0, gc);
      for (int i = 0; i < 800 && got_q.size() < 13; i++) begin
         @(negedge clk);
         #2;
      end
      total++;
      if (got_q.size() < 13) begin
         bad++;
         $display("FAIL loop_timeout: got %0d starts want 13", got_q.size());
      end
      repeat (4) @(negedge clk);
      #2;
      total++;
      if (led_a !== 4'b0001) begin
         bad++;
         $display("FAIL loop_led_ramp: got %b want 0001", led_a);
      end
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      #2;
      total++;
      if (led_a !== '0 || busy_a !== 1'b0) begin
         bad++;
         $display("FAIL loop_stop: got led=%b busy=%b want 0000 and 0", led_a, busy_a);
      end
      ns = got_q.size();
      repeat (60) @(negedge clk);
      #2;
      total++;
      if (got_q.size() != ns || done_cnt != d0) begin
         bad++;
         $display("FAIL loop_after_stop: got starts=%0d dones=%0d want %0d and 0",
                  got_q.size(), done_cnt - d0, ns);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL loop_idx[%0d]: got %0d want %0d", i, g, e); end
      end
      pwm_level = 1'b0;
   endtask

   task automatic test_spurious;
      int gc, d0, n, inj;
      bit ok;
      logic [IW-1:0] e, g;
      @(negedge clk);
      spur_done = 1'b1;
      repeat (2) @(negedge clk);
      spur_done = 1'b0;
      #2;
      total++;
      if (busy_a !== 1'b0 || rs_a !== 1'b0) begin
         bad++;
         $display("FAIL spur_idle: got busy=%b start=%b want 0 and 0", busy_a, rs_a);
      end
      d0 = done_cnt;
      for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
      start_seq(2'b00, '0, gc);
      ok = 1'b0;
      inj = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         spur_done = 1'b0;
         go = 1'b0;
         if (cyc == last_rd_cyc + 1 && inj < 4) begin
            spur_done = 1'b1;
            go = 1'b1;
            mode = 2'b11;
            inj++;
         end
         #2;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
      spur_done = 1'b0;
      go = 1'b0;
      total++;
      if (!ok || inj < 3) begin
         bad++;
         $display("FAIL spur_timeout: got done=%b injections=%0d want 1 and >=3", ok, inj);
      end
      for (int i = 1; i < start_q.size(); i++) begin
         total++;
         if (start_q[i] - start_q[i-1] !== 23) begin
            bad++;
            $display("FAIL spur_spacing[%0d]: got %0d want 23", i, start_q[i] - start_q[i-1]);
         end
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL spur_idx[%0d]: got %0d want %0d", i, g, e); end
      end
      total++;
      if (got_q.size() != 0 || done_cnt - d0 != 1) begin
         bad++;
         $display("FAIL spur_counts: got extra_starts=%0d dones=%0d want 0 and 1",
                  got_q.size(), done_cnt - d0);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reverse_gap0;
      int gc, d0, n, l0, s0;
      bit ok;
      logic [IW-1:0] e, g;
      @(negedge clk);
      rst_a = 1'b0;
      sel = 1'b1;
      pwm_tog_en = 1'b1;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      d0 = done_cnt;
      l0 = lit_cnt;
      s0 = stray_cnt;
      for (int i = N - 1; i >= 0; i--) exp_q.push_back(IW'(i));
      start_seq(2'b11, '0, gc);
      wait_done(400, d0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rev_timeout: got no seq_done want one"); end
      for (int i = 1; i < start_q.size(); i++) begin
         total++;
         if (start_q[i] - start_q[i-1] !== RD_DELAY + 1) begin
            bad++;
            $display("FAIL rev_spacing[%0d]: got %0d want %0d", i,
                     start_q[i] - start_q[i-1], RD_DELAY + 1);
         end
      end
      total++;
      if (done_cyc - last_rd_cyc !== 1) begin
         bad++;
         $display("FAIL rev_done_lat: got %0d want 1", done_cyc - last_rd_cyc);
      end
      total++;
      if (lit_cnt - l0 !== N * RD_DELAY / 2 || stray_cnt != s0) begin
         bad++;
         $display("FAIL rev_pwm: got lit=%0d stray=%0d want %0d and 0",
                  lit_cnt - l0, stray_cnt - s0, N * RD_DELAY / 2);
      end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL rev_idx[%0d]: got %0d want %0d", i, g, e); end
      end
      @(negedge clk);
      pwm_tog_en = 1'b0;
      rst_b = 1'b0;
      sel = 1'b0;
      rst_a = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int gc, d0, n;
      bit ok;
      logic [IW-1:0] e, g;
      start_seq(2'b01, '0, gc);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #2;
         if (start_q.size() >= 2 && last_rd_cyc > start_q[1]) begin
            ok = 1'b1;
            break;
         end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL rmid_timeout: got no second ramp_done want one"); end
      @(negedge clk);
      rst_a = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      #2;
      total++;
      if ({rs_a, led_a, idx_a, busy_a, sd_a} !== '0) begin
         bad++;
         $display("FAIL rmid_outputs: got start=%b led=%b idx=%0d busy=%b done=%b want all 0",
                  rs_a, led_a, idx_a, busy_a, sd_a);
      end
      repeat (30) @(negedge clk);
      d0 = done_cnt;
      for (int i = 0; i < N; i++) exp_q.push_back(IW'(i));
      start_seq(2'b00, '0, gc);
      wait_done(400, d0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rmid_restart: got no seq_done want one"); end
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
         total++;
         if (g !== e) begin bad++; $display("FAIL rmid_idx[%0d]: got %0d want %0d", i, g, e); end
      end
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      go = 1'b0;
      stop = 1'b0;
      sel = 1'b0;
      mode = 2'b00;
      repeats = '0;
      spur_done = 1'b0;
      pwm_level = 1'b0;
      pwm_tog_en = 1'b0;
      test_reset();
      test_fwd_single();
      test_pingpong();
      test_loop_stop();
      test_spurious();
      test_reverse_gap0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
